adder_response_checker: RTL and testbench

Sequential self-check engine that is the receiving end of the adder stimulus flow. It drives every input combination into a combinational adder under test (full adder at WIDTH=1, ripple adder at larger widths), samples the adder's sum and carry after a programmable settle time, and compares them against the arithmetic reference. It reports pass/fail, an error count and the first failing vector. It sits beside the adder on an FPGA bring-up or self-test harness, so a bench no longer has to check outputs by hand.

---
 rtl/adder_response_checker.sv | 91 +++++++++
 tb/tb_adder_response_checker.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_response_checker.sv
// Exhaustive sweep checker for a combinational adder: drives every {a,b,cin}
// vector, samples {cout,sum} after SETTLE wait cycles and tallies mismatches.
module adder_response_checker #(
   parameter int WIDTH  = 1,
   parameter int SETTLE = 1,
   parameter int ERR_W  = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic [WIDTH-1:0]   a_o,
   output logic [WIDTH-1:0]   b_o,
   output logic               cin_o,
   input  logic [WIDTH-1:0]   sum_i,
   input  logic               cout_i,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [ERR_W-1:0]   err_count,
   output logic [2*WIDTH:0]   first_fail
);

   localparam int VW = 2*WIDTH+1;

   typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_WAIT, S_CHECK, S_DONE} state_t;

   state_t           state, state_nxt;
   logic [VW-1:0]    v;
   logic [3:0]       settle_cnt;
   logic [WIDTH:0]   expected;
   logic             mismatch;
   logic             last_vec;
   logic             launch;

   // The vector register is the operand register, so a_o/b_o/cin_o are flops.
   assign {a_o, b_o, cin_o} = v;

   assign expected = (WIDTH+1)'(a_o) + (WIDTH+1)'(b_o) + (WIDTH+1)'(cin_o);
   assign mismatch = ({cout_i, sum_i} != expected);
   assign last_vec = (v == '1);
   assign launch   = start && ((state == S_IDLE) || (state == S_DONE));

   assign busy = (state == S_DRIVE) || (state == S_WAIT) || (state == S_CHECK);
   assign done = (state == S_DONE);
   assign pass = done && (err_count == '0);

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: if (start) state_nxt = S_DRIVE;
         S_DRIVE:        state_nxt = (SETTLE == 0) ? S_CHECK : S_WAIT;
         S_WAIT:         if (settle_cnt == 4'(SETTLE-1)) state_nxt = S_CHECK;
         S_CHECK:        state_nxt = last_vec ? S_DONE : S_DRIVE;
         default:        state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v          <= '0;
         settle_cnt <= '0;
         err_count  <= '0;
         first_fail <= '0;
      end else if (launch) begin
         v          <= '0;
         settle_cnt <= '0;
         err_count  <= '0;
         first_fail <= '0;
      end else begin
         case (state)
            S_DRIVE: settle_cnt <= '0;
            S_WAIT:  settle_cnt <= settle_cnt + 4'd1;
            S_CHECK: begin
               if (mismatch) begin
                  if (err_count != '1) err_count <= err_count + 1'b1;
                  if (err_count == '0) first_fail <= v;
               end
               // Wrapping N-1 -> 0 also parks the operands at zero in DONE.
               v <= v + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_adder_response_checker.sv
// Bench for adder_response_checker: three configurations, each fed by a
// fault-injectable adder model and checked against a sweep-level reference.
module tb_adder_response_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;

   logic [2:0] rst;
   logic [2:0] start;
   int         mode [3];
   logic       bad  [3][32];

   int wid  [3] = '{1, 2, 1};
   int setl [3] = '{1, 0, 3};
   int emax [3] = '{65535, 65535, 3};

   // Adder under test: 0 correct, 1 cout stuck at 0, 2 sum inverted, 3 bit0 flipped on chosen vectors
   function automatic int adder_resp(input int w, input int m, input logic bd, input int vi);
      int a, b, c, good;
      a = vi >> (w+1);
      b = (vi >> 1) & ((1 << w) - 1);
      c = vi & 1;
      good = a + b + c;
      case (m)
         1: return good & ((1 << w) - 1);
         2: return good ^ ((1 << w) - 1);
         3: return bd ? (good ^ 1) : good;
         default: return good;
      endcase
   endfunction

   logic [0:0] a0, b0, s0, a2, b2, s2;
   logic [1:0] a1, b1, s1;
   logic       c0, c1, c2, co0, co1, co2;
   logic [2:0] ff0, ff2;
   logic [4:0] ff1;
   logic [15:0] e0, e1;
   logic [1:0]  e2;
   wire  [2:0] busy, done, pass;
   int r0, r1, r2;

   always_comb r0 = adder_resp(1, mode[0], bad[0][{a0, b0, c0}], int'({a0, b0, c0}));
   always_comb r1 = adder_resp(2, mode[1], bad[1][{a1, b1, c1}], int'({a1, b1, c1}));
   always_comb r2 = adder_resp(1, mode[2], bad[2][{a2, b2, c2}], int'({a2, b2, c2}));
   assign s0 = r0[0];   assign co0 = r0[1];
   assign s1 = r1[1:0]; assign co1 = r1[2];
   assign s2 = r2[0];   assign co2 = r2[1];

   wire [4:0]  vec  [3];
   wire [15:0] errv [3];
   wire [4:0]  ffv  [3];
   assign vec[0]  = {2'b00, a0, b0, c0};
   assign vec[1]  = {a1, b1, c1};
   assign vec[2]  = {2'b00, a2, b2, c2};
   assign errv[0] = e0;
   assign errv[1] = e1;
   assign errv[2] = {14'd0, e2};
   assign ffv[0]  = {2'b00, ff0};
   assign ffv[1]  = ff1;
   assign ffv[2]  = {2'b00, ff2};

   adder_response_checker #(.WIDTH(1), .SETTLE(1), .ERR_W(16)) dut0 (
      .clk(clk), .rst(rst[0]), .start(start[0]), .a_o(a0), .b_o(b0), .cin_o(c0),
      .sum_i(s0), .cout_i(co0), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
      .err_count(e0), .first_fail(ff0));

   adder_response_checker #(.WIDTH(2), .SETTLE(0), .ERR_W(16)) dut1 (
      .clk(clk), .rst(rst[1]), .start(start[1]), .a_o(a1), .b_o(b1), .cin_o(c1),
      .sum_i(s1), .cout_i(co1), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
      .err_count(e1), .first_fail(ff1));

   adder_response_checker #(.WIDTH(1), .SETTLE(3), .ERR_W(2)) dut2 (
      .clk(clk), .rst(rst[2]), .start(start[2]), .a_o(a2), .b_o(b2), .cin_o(c2),
      .sum_i(s2), .cout_i(co2), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
      .err_count(e2), .first_fail(ff2));

   task automatic check_idle(input int d, input string name);
      compared++;
      if (vec[d] !== 5'd0 || busy[d] !== 1'b0 || done[d] !== 1'b0 || pass[d] !== 1'b0 ||
          errv[d] !== 16'd0 || ffv[d] !== 5'd0) begin
         mismatched++;
         $display("FAIL %s dut%0d: vec=%0d busy=%b done=%b pass=%b err=%0d ff=%0d, required all zero",
                  name, d, vec[d], busy[d], done[d], pass[d], errv[d], ffv[d]);
      end
   endtask

   task automatic test_reset();
      rst = 3'b111; start = 3'b000;
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) check_idle(d, "reset");
      @(negedge clk); rst = 3'b000;
   endtask

   // Full sweep on instance d, reference computed from {cout,sum} = a+b+cin per vector
   task automatic run_sweep(input int d, input string name);
      int n, per, len, exp_err, exp_ff, good, got;
      n = 1 << (2*wid[d]+1);
      per = 2 + setl[d];
      len = n * per;
      exp_err = 0; exp_ff = 0;
      for (int vi = 0; vi < n; vi++) begin
         good = (vi >> (wid[d]+1)) + ((vi >> 1) & ((1 << wid[d]) - 1)) + (vi & 1);
         got  = adder_resp(wid[d], mode[d], bad[d][vi], vi);
         if (got != good) begin
            if (exp_err == 0) exp_ff = vi;
            exp_err++;
         end
      end
      if (exp_err > emax[d]) exp_err = emax[d];
      @(negedge clk); start[d] = 1'b1;
      @(posedge clk); #1; start[d] = 1'b0;
      for (int k = 0; k < len; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         compared++;
         if (vec[d] !== 5'(k/per) || busy[d] !== 1'b1 || done[d] !== 1'b0) begin
            mismatched++;
            $display("FAIL %s seq dut%0d edge %0d: vec=%0d busy=%b done=%b, required vec=%0d busy=1 done=0",
                     name, d, k, vec[d], busy[d], done[d], k/per);
         end
      end
      @(posedge clk); #1;
      compared++;
      if (done[d] !== 1'b1 || busy[d] !== 1'b0 || vec[d] !== 5'd0) begin
         mismatched++;
         $display("FAIL %s end dut%0d edge %0d: done=%b busy=%b vec=%0d, required done=1 busy=0 vec=0",
                  name, d, len, done[d], busy[d], vec[d]);
      end
      compared++;
      if (errv[d] !== 16'(exp_err)) begin
         mismatched++;
         $display("FAIL %s err_count dut%0d: got %0d, required %0d", name, d, errv[d], exp_err);
      end
      compared++;
      if (ffv[d] !== 5'(exp_ff)) begin
         mismatched++;
         $display("FAIL %s first_fail dut%0d: got %0d, required %0d", name, d, ffv[d], exp_ff);
      end
      compared++;
      if (pass[d] !== (exp_err == 0)) begin
         mismatched++;
         $display("FAIL %s pass dut%0d: got %b, required %b", name, d, pass[d], exp_err == 0);
      end
   endtask

   task automatic test_clean_w1();     mode[0] = 0; run_sweep(0, "clean_w1");     endtask
   task automatic test_cout_stuck();   mode[0] = 1; run_sweep(0, "cout_stuck");   endtask
   task automatic test_sum_inverted(); mode[0] = 2; run_sweep(0, "sum_inverted"); endtask
   task automatic test_back_to_back(); mode[0] = 0; run_sweep(0, "back_to_back"); endtask
   task automatic test_w2_settle0();   mode[1] = 0; run_sweep(1, "w2_settle0");   endtask
   task automatic test_saturate();     mode[2] = 2; run_sweep(2, "saturate");     endtask

   task automatic test_mid_reset();
      mode[0] = 2;
      @(negedge clk); start[0] = 1'b1;
      @(posedge clk); #1;
      for (int k = 1; k < 10; k++) begin
         @(negedge clk); start[0] = (k == 5);
         @(posedge clk); #1;
         compared++;
         if (vec[0] !== 5'(k/3) || busy[0] !== 1'b1) begin
            mismatched++;
            $display("FAIL mid_reset seq edge %0d: vec=%0d busy=%b, required vec=%0d busy=1",
                     k, vec[0], busy[0], k/3);
         end
      end
      @(negedge clk); start[0] = 1'b0; rst[0] = 1'b1;
      @(posedge clk); #1;
      check_idle(0, "mid_reset");
      @(negedge clk); start[0] = 1'b1;
      @(posedge clk); #1;
      check_idle(0, "rst_priority");
      @(negedge clk); start[0] = 1'b0; rst[0] = 1'b0;
      @(posedge clk); #1;
      check_idle(0, "after_reset");
   endtask

   task automatic test_random();
      int d;
      for (int i = 0; i < 8; i++) begin
         d = int'($urandom_range(0, 2));
         mode[d] = int'($urandom_range(0, 3));
         for (int vi = 0; vi < 32; vi++) bad[d][vi] = ($urandom_range(0, 3) == 0);
         repeat ($urandom_range(0, 5)) @(posedge clk);
         run_sweep(d, "random");
      end
   endtask

   initial begin
      rst = 3'b111; start = 3'b000;
      for (int d = 0; d < 3; d++) begin
         mode[d] = 0;
         for (int vi = 0; vi < 32; vi++) bad[d][vi] = 1'b0;
      end
      test_reset();
      test_clean_w1();
      test_cout_stuck();
      test_sum_inverted();
      test_back_to_back();
      test_mid_reset();
      test_w2_settle0();
      test_saturate();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
